// File: rtl/mq_traffic_gen.sv
// Multi-channel C2H traffic generator: NUM_CH packet streams round-robin arbitrated onto one AXI-Stream master.
// Optional build macro SEQ_STAMP_EN: payload bytes 14-15 carry a per-channel 16-bit packet sequence number.
module mq_traffic_gen #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 512,
  parameter int          MAX_FRAME = 4096,
  parameter int          CRD_W     = 16,
  parameter logic [47:0] DST_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_02,
  localparam int         BYTES     = DATA_W / 8,
  localparam int         QW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH*16-1:0] pkt_len,
  input  logic [NUM_CH*16-1:0] num_pkt,
  input  logic [NUM_CH*32-1:0] gap_cycles,
  input  logic                 credit_vld,
  input  logic [QW-1:0]        credit_qid,
  input  logic [CRD_W-1:0]     credit_in,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic [BYTES-1:0]     m_tkeep,
  output logic                 m_tlast,
  output logic [QW-1:0]        m_tqid,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state_o
);
  // AXIS handshake: a beat moves on a cycle where m_tvalid && m_tready; while m_tvalid is high
  // and m_tready is low, every m_t* output holds. A packet's beats are sent with no gaps.
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, SEND = 2'd2} state_e;

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, 16'h2121};

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  en_q;
  logic [15:0]        len_q    [NUM_CH];
  logic [31:0]        gap_q    [NUM_CH];
  logic [15:0]        rem_q    [NUM_CH];
  logic [31:0]        gcnt_q   [NUM_CH];
  logic [CRD_W-1:0]   credit_q [NUM_CH];
  logic [CRD_W-1:0]   credit_d [NUM_CH];
  logic [CRD_W:0]     csum     [NUM_CH];
  logic [QW-1:0]      last_q, cur_ch_q;
  logic [15:0]        cur_len_q, beat_q, n_beats;
  logic               stop_pend_q, done_q;
`ifdef SEQ_STAMP_EN
  logic [15:0]        seq_q [NUM_CH];
  logic [15:0]        cur_seq_q;
`endif

  logic [NUM_CH-1:0]  elig;
  logic               any_rem, grant_vld, take, done_set, start_acc, beat_acc, is_last;
  logic [QW-1:0]      grant_ch, cand;
  logic [31:0]        pos;

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (l < 16'd64) return 16'd64;
    if (32'(l) > 32'(MAX_FRAME)) return 16'(MAX_FRAME);
    return l;
  endfunction

  always_comb begin
    elig    = '0;
    any_rem = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = en_q[c] && (rem_q[c] != '0) && (credit_q[c] != '0) && (gcnt_q[c] >= gap_q[c]);
      any_rem = any_rem | (rem_q[c] != '0);
    end
  end

  // Round-robin: the search begins one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = QW'((int'(last_q) + 1 + i) % NUM_CH);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign start_acc = (state_q == IDLE) && start;
  assign beat_acc  = m_tvalid && m_tready;
  assign n_beats   = 16'((32'(cur_len_q) + 32'(BYTES) - 32'd1) / 32'(BYTES));
  assign is_last   = (beat_q == n_beats - 16'd1);

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = ARB;
      ARB: begin
        if (stop || !any_rem) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else if (grant_vld) begin
          state_d = SEND;
          take    = 1'b1;
        end
      end
      SEND: begin
        if (beat_acc && is_last) begin
          if (!any_rem || stop_pend_q || stop) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end else begin
            state_d = ARB;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit add and consume in the same cycle net out before saturating.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      csum[c] = {1'b0, credit_q[c]};
      if (credit_vld && (credit_qid == QW'(c))) csum[c] = csum[c] + {1'b0, credit_in};
      if (take && (grant_ch == QW'(c))) csum[c] = csum[c] - 1'b1;
      credit_d[c] = csum[c][CRD_W] ? '1 : csum[c][CRD_W-1:0];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      en_q        <= '0;
      last_q      <= QW'(NUM_CH - 1);
      cur_ch_q    <= '0;
      cur_len_q   <= '0;
      beat_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        len_q[c]    <= '0;
        gap_q[c]    <= '0;
        rem_q[c]    <= '0;
        gcnt_q[c]   <= '0;
        credit_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start_acc) done_q <= 1'b0;
      else if (done_set) done_q <= 1'b1;
      if (state_q == IDLE) stop_pend_q <= 1'b0;
      else if (stop && (state_q == SEND)) stop_pend_q <= 1'b1;
      if (start_acc) begin
        en_q   <= ch_en;
        last_q <= QW'(NUM_CH - 1);
      end else if (take) begin
        last_q    <= grant_ch;
        cur_ch_q  <= grant_ch;
        cur_len_q <= len_q[grant_ch];
        beat_q    <= '0;
      end else if (beat_acc) begin
        beat_q <= beat_q + 16'd1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        credit_q[c] <= credit_d[c];
        if (start_acc) begin
          len_q[c]  <= clamp_len(pkt_len[16*c +: 16]);
          gap_q[c]  <= gap_cycles[32*c +: 32];
          rem_q[c]  <= ch_en[c] ? num_pkt[16*c +: 16] : 16'd0;
          gcnt_q[c] <= '1;
        end else if (take && (grant_ch == QW'(c))) begin
          rem_q[c]  <= rem_q[c] - 16'd1;
          gcnt_q[c] <= '0;
        end else if (gcnt_q[c] != '1) begin
          gcnt_q[c] <= gcnt_q[c] + 32'd1;
        end
      end
    end
  end

`ifdef SEQ_STAMP_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cur_seq_q <= '0;
      for (int c = 0; c < NUM_CH; c++) seq_q[c] <= '0;
    end else if (start_acc) begin
      for (int c = 0; c < NUM_CH; c++) seq_q[c] <= '0;
    end else if (take) begin
      cur_seq_q       <= seq_q[grant_ch];
      seq_q[grant_ch] <= seq_q[grant_ch] + 16'd1;
    end
  end
`endif

  // Payload bytes are a pure function of (beat, byte lane, length), so they hold under backpressure.
  always_comb begin
    m_tdata = '0;
    m_tkeep = '0;
    pos     = '0;
    if (state_q == SEND) begin
      for (int k = 0; k < BYTES; k++) begin
        pos = 32'(beat_q) * 32'(BYTES) + 32'(k);
        if (pos < 32'(cur_len_q)) begin
          m_tkeep[k] = 1'b1;
          if (pos < 32'd14) begin
            m_tdata[8*k +: 8] = 8'(HDR >> (32'd8 * (32'd13 - pos)));
`ifdef SEQ_STAMP_EN
          end else if (pos == 32'd14) begin
            m_tdata[8*k +: 8] = cur_seq_q[7:0];
          end else if (pos == 32'd15) begin
            m_tdata[8*k +: 8] = cur_seq_q[15:8];
`endif
          end else if (pos == 32'(cur_len_q) - 32'd1) begin
            m_tdata[8*k +: 8] = 8'h0a;
          end else if (pos >= 32'(cur_len_q) - 32'd4) begin
            m_tdata[8*k +: 8] = 8'h21;
          end else begin
            m_tdata[8*k +: 8] = 8'h41;
          end
        end
      end
    end
  end

  assign m_tvalid    = (state_q == SEND);
  assign m_tlast     = (state_q == SEND) && is_last;
  assign m_tqid      = (state_q == SEND) ? cur_ch_q : '0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mq_traffic_gen.sv
// Testbench for mq_traffic_gen: directed scenarios plus randomized runs, checked by a per-channel scoreboard.
module tb_mq_traffic_gen;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 512;
  localparam int BYTES     = DATA_W / 8;
  localparam int MAX_FRAME = 4096;
  localparam int CRD_W     = 16;
  localparam int QW        = 2;
  localparam logic [47:0] DST = 48'h0a_1b_2c_3d_4e_5f;
  localparam logic [47:0] SRC = 48'h00_11_22_33_44_55;
  localparam int EW = 4 + 1 + BYTES + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 start = 1'b0, stop = 1'b0;
  logic [NUM_CH-1:0]    ch_en = '0;
  logic [NUM_CH*16-1:0] pkt_len = '0, num_pkt = '0;
  logic [NUM_CH*32-1:0] gap_cycles = '0;
  logic                 credit_vld = 1'b0;
  logic [QW-1:0]        credit_qid = '0;
  logic [CRD_W-1:0]     credit_in = '0;
  logic                 m_tvalid, m_tready, m_tlast, busy, done;
  logic [DATA_W-1:0]    m_tdata;
  logic [BYTES-1:0]     m_tkeep;
  logic [QW-1:0]        m_tqid;
  logic [1:0]           dbg_state;
  bit                   rnd_ready = 1'b0;

  mq_traffic_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_FRAME(MAX_FRAME), .CRD_W(CRD_W),
                   .DST_MAC(DST), .SRC_MAC(SRC)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .start(start), .stop(stop), .ch_en(ch_en),
    .pkt_len(pkt_len), .num_pkt(num_pkt), .gap_cycles(gap_cycles), .credit_vld(credit_vld),
    .credit_qid(credit_qid), .credit_in(credit_in), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tqid(m_tqid), .busy(busy),
    .done(done), .dbg_state_o(dbg_state));

  // ---------------- checking ----------------
  int checks = 0, passed = 0;
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [3:0]    ord_q[$];
  bit            ord_en = 1'b0;
  logic [15:0]   seq_cnt[NUM_CH];
  int            cfg_len[NUM_CH], cfg_num[NUM_CH];

  // Builds the packet as a byte array from the payload rules, then slices it into beats.
  task automatic push_pkt(input int ch, input int raw_len);
    logic [7:0] pk[];
    logic [111:0] hdr;
    logic [DATA_W-1:0] d;
    logic [BYTES-1:0] kp;
    int len, nb, p;
    len = (raw_len < 64) ? 64 : (raw_len > MAX_FRAME) ? MAX_FRAME : raw_len;
    hdr = {DST, SRC, 16'h2121};
    pk = new[len];
    for (int i = 0; i < len; i++) pk[i] = 8'h41;
    for (int i = 0; i < 14; i++) pk[i] = hdr[111 - 8*i -: 8];
`ifdef SEQ_STAMP_EN
    pk[14] = seq_cnt[ch][7:0];
    pk[15] = seq_cnt[ch][15:8];
`endif
    pk[len-4] = 8'h21; pk[len-3] = 8'h21; pk[len-2] = 8'h21; pk[len-1] = 8'h0a;
    seq_cnt[ch] = seq_cnt[ch] + 16'd1;
    nb = (len + BYTES - 1) / BYTES;
    for (int b = 0; b < nb; b++) begin
      d = '0; kp = '0;
      for (int k = 0; k < BYTES; k++) begin
        p = b * BYTES + k;
        if (p < len) begin
          d[8*k +: 8] = pk[p];
          kp[k] = 1'b1;
        end
      end
      exp_q.push_back({4'(ch), (b == nb - 1), kp, d});
    end
  endtask

  // ---------------- monitor ----------------
  bit                in_pkt = 1'b0, prev_stall = 1'b0;
  logic [QW-1:0]     cur_q;
  logic [DATA_W-1:0] prev_data;
  logic [66:0]       prev_ctl;
  int                sop_cnt[NUM_CH], last_sop_t[NUM_CH], min_space[NUM_CH];

  always @(negedge clk) begin : monitor
    int idx;
    logic [EW-1:0] e;
    logic [DATA_W-1:0] msk;
    if (!rst_n) begin
      in_pkt = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_ctl", {m_tkeep, m_tlast, m_tqid}, prev_ctl);
      end
      if (in_pkt && !prev_stall) check("no_bubble", m_tvalid, 1);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_ctl   = {m_tkeep, m_tlast, m_tqid};
      if (m_tvalid && m_tready) begin
        if (!in_pkt) begin
          cur_q = m_tqid;
          sop_cnt[m_tqid]++;
          if (last_sop_t[m_tqid] >= 0 && (cyc - last_sop_t[m_tqid]) < min_space[m_tqid])
            min_space[m_tqid] = cyc - last_sop_t[m_tqid];
          last_sop_t[m_tqid] = cyc;
          if (ord_en) begin
            if (ord_q.size() == 0) check("order_extra_pkt", 1, 0);
            else check("order_tqid", m_tqid, ord_q.pop_front());
          end
        end else begin
          check("tqid_const", m_tqid, cur_q);
        end
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i][EW-1 -: 4] == 4'(m_tqid)) idx = i;
        if (idx < 0) begin
          check("beat_expected", 0, 1);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          msk = '0;
          for (int k = 0; k < BYTES; k++) if (m_tkeep[k]) msk[8*k +: 8] = 8'hFF;
          check("tdata", m_tdata & msk, e[DATA_W-1:0] & msk);
          check("tkeep", m_tkeep, e[DATA_W +: BYTES]);
          check("tlast", m_tlast, e[EW-5]);
        end
        in_pkt = !m_tlast;
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      sop_cnt[c] = 0; last_sop_t[c] = -1; min_space[c] = 1000000;
    end
  endtask

  task automatic set_ch(input int c, input bit en, input int len, input int num, input int gap);
    ch_en[c] = en;
    pkt_len[16*c +: 16] = 16'(len);
    num_pkt[16*c +: 16] = 16'(num);
    gap_cycles[32*c +: 32] = 32'(gap);
    cfg_len[c] = len;
    cfg_num[c] = num;
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 64, 0, 0);
  endtask

  task automatic give_credit(input int ch, input int n);
    credit_vld = 1'b1; credit_qid = QW'(ch); credit_in = CRD_W'(n);
    tick(1);
    credit_vld = 1'b0;
  endtask

  task automatic run_start();
    clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      seq_cnt[c] = 16'd0;
      if (ch_en[c]) for (int p = 0; p < cfg_num[c]; p++) push_pkt(c, cfg_len[c]);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared_by_start", done, 0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin tick(1); n++; end
    check(name, done, 1);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    clear_stats();
    for (int c = 0; c < NUM_CH; c++) seq_cnt[c] = 16'd0;
    clear_cfg();
    tick(2);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_outputs", {m_tlast, m_tkeep, m_tqid, busy, done}, 0);
    check("rst_tdata", m_tdata, 0);
    rst_n = 1'b1;
    tick(1);

    // single channel, three one-beat packets
    set_ch(0, 1'b1, 64, 3, 0);
    give_credit(0, 3);
    ord_en = 1'b1;
    repeat (3) ord_q.push_back(4'd0);
    run_start();
    wait_done(200, "t1_done");
    check("t1_pkts", sop_cnt[0], 3);
    check("t1_sb_empty", exp_q.size(), 0);

    // four channels round-robin; a start while busy must be ignored
    for (int c = 0; c < NUM_CH; c++) begin set_ch(c, 1'b1, 200, 2, 0); give_credit(c, 8); end
    for (int r = 0; r < 2; r++) for (int c = 0; c < NUM_CH; c++) ord_q.push_back(4'(c));
    run_start();
    tick(6);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done(400, "t2_done");
    check("t2_order_consumed", ord_q.size(), 0);
    check("t2_sb_empty", exp_q.size(), 0);
    ord_en = 1'b0;

    // credit starvation, then credit arrival
    do_reset();
    clear_cfg();
    set_ch(1, 1'b1, 64, 2, 0);
    run_start();
    tick(100);
    check("t3_no_pkts_without_credit", sop_cnt[1], 0);
    check("t3_still_busy", busy, 1);
    give_credit(1, 2);
    wait_done(200, "t3_done");
    check("t3_pkts", sop_cnt[1], 2);
    check("t3_sb_empty", exp_q.size(), 0);

    // inter-packet gap
    clear_cfg();
    set_ch(0, 1'b1, 64, 3, 50);
    give_credit(0, 3);
    run_start();
    wait_done(500, "t4_done");
    check("t4_pkts", sop_cnt[0], 3);
    check("t4_spacing_ge_50", min_space[0] >= 50, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // backpressure with 130-byte packets on two channels
    rnd_ready = 1'b1;
    clear_cfg();
    set_ch(0, 1'b1, 130, 3, 0);
    set_ch(2, 1'b1, 130, 3, 0);
    give_credit(0, 3); give_credit(2, 3);
    run_start();
    wait_done(1000, "t5_done");
    check("t5_pkts", sop_cnt[0] + sop_cnt[2], 6);
    check("t5_sb_empty", exp_q.size(), 0);

    // stop in the middle of a packet
    clear_cfg();
    set_ch(0, 1'b1, 130, 10, 0);
    give_credit(0, 10);
    run_start();
    n = 0;
    while (!in_pkt && n < 200) begin tick(1); n++; end
    check("t5_reached_mid_pkt", in_pkt, 1);
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_done(200, "t5_stop_done");
    check("t5_stop_tlast_delivered", in_pkt, 0);
    check("t5_stop_one_pkt", sop_cnt[0], 1);
    exp_q.delete();
    rnd_ready = 1'b0;

    // stop while waiting in arbitration (no credit on ch1)
    clear_cfg();
    set_ch(1, 1'b1, 64, 2, 0);
    run_start();
    tick(5);
    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_arb_done_next", done, 1);
    check("stop_arb_busy_low", busy, 0);
    check("stop_arb_no_pkts", sop_cnt[1], 0);
    exp_q.delete();
    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_idle_ignored", {busy, done}, 2'b01);

    // nothing enabled: done two cycles after start
    clear_cfg();
    run_start();
    tick(1);
    check("empty_run_done", done, 1);
    check("empty_run_busy", busy, 0);

    // randomized configurations
    rnd_ready = 1'b1;
    for (int it = 0; it < 4; it++) begin
      clear_cfg();
      for (int c = 0; c < NUM_CH; c++) begin
        set_ch(c, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 5000 : $urandom_range(1, 300),
               $urandom_range(0, 3), $urandom_range(0, 20));
        give_credit(c, cfg_num[c] + $urandom_range(0, 2));
      end
      run_start();
      wait_done(20000, "rand_done");
      for (int c = 0; c < NUM_CH; c++) check("rand_pkts", sop_cnt[c], ch_en[c] ? cfg_num[c] : 0);
      check("rand_sb_empty", exp_q.size(), 0);
    end
    rnd_ready = 1'b0;

    // asynchronous reset in the middle of a long packet
    clear_cfg();
    set_ch(0, 1'b1, 4096, 1, 0);
    give_credit(0, 1);
    run_start();
    n = 0;
    while (!m_tvalid && n < 50) begin tick(1); n++; end
    tick(3);
    check("rst_mid_pkt_active", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_tvalid_low", m_tvalid, 0);
    check("rst_mid_busy_low", busy, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_idle", {m_tvalid, busy, done}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
